// File: rtl/sr_ff_pkg.sv
// Shared encodings for the SR flip-flop arbiter: FSM states, operation codes,
// settle counter width and the debug view of the controller state.
package sr_ff_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_CHECK  = 2'd3;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  typedef struct packed {
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             exp_bit;
    logic             last;
  } sr_ff_dbg_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone request wins, on contention the
// requester that was not served last wins.
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = 2'b00;
    case (i_req)
      2'b01:   o_pick = 2'b01;
      2'b10:   o_pick = 2'b10;
      2'b11:   o_pick = i_last ? 2'b01 : 2'b10;
      default: o_pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/sr_ff_arbiter.sv
// Arbitrates two requesters onto one shared SR master-slave flip-flop:
// drive pulse, settle hold with R=S=0, then readback check of Q.
module sr_ff_arbiter
  import sr_ff_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter bit          CHECK_EN   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_l,
  input  logic [1:0] i_req,
  input  logic [1:0] i_op,
  input  logic       i_err_clr,
  input  logic       i_q_fb,
  output logic [1:0] o_gnt,
  output logic       o_r,
  output logic       o_s,
  output logic       o_done,
  output logic       o_err,
  output sr_ff_dbg_t o_dbg
);

  // Handshake: a requester raises REQ[i] and holds it; GNT[i] marks acceptance
  // and the one-cycle DONE pulse (with GNT still high) completes the operation.

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_exp;
  logic             r_last;
  logic [1:0]       r_gnt;
  logic             r_r;
  logic             r_s;
  logic             r_done;
  logic             r_err;

  logic [1:0]       w_pick;
  logic [1:0]       w_state_nx;
  logic             w_start;
  logic             w_exp_next;
  logic             w_settle_end;
  logic             w_mismatch;

  rr_pick2 u_pick (
    .i_req  (i_req),
    .i_last (r_last),
    .o_pick (w_pick)
  );

  assign w_start      = (r_state == ST_IDLE) && (|i_req);
  assign w_exp_next   = |(i_op & w_pick);
  assign w_settle_end = (r_state == ST_SETTLE) && (r_cnt <= CNT_W'(1));
  assign w_mismatch   = CHECK_EN && (i_q_fb != r_exp);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:   if (|i_req) w_state_nx = ST_DRIVE;
      ST_DRIVE:  w_state_nx = ST_SETTLE;
      ST_SETTLE: if (w_settle_end) w_state_nx = ST_CHECK;
      ST_CHECK:  w_state_nx = ST_IDLE;
      default:   w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l) r_state <= ST_IDLE;
    else            r_state <= w_state_nx;
  end

  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l)                               r_cnt <= '0;
    else if (w_start)                             r_cnt <= CNT_W'(SETTLE_CYC);
    else if (r_state == ST_SETTLE && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
  end

  // Operation type and winner are frozen at grant; later REQ/OP edges are ignored.
  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_exp  <= 1'b0;
      r_last <= 1'b1;
      r_gnt  <= 2'b00;
    end else if (w_start) begin
      r_exp  <= w_exp_next;
      r_last <= w_pick[1];
      r_gnt  <= w_pick;
    end else if (r_state == ST_CHECK) begin
      r_gnt  <= 2'b00;
    end
  end

  // Both drives derive from the same latched bit, so they can never overlap.
  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l) begin
      r_s <= 1'b0;
      r_r <= 1'b0;
    end else begin
      r_s <= w_start && (w_exp_next == OP_SET);
      r_r <= w_start && (w_exp_next == OP_CLR);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l) r_done <= 1'b0;
    else            r_done <= w_settle_end;
  end

  always_ff @(posedge i_clk or negedge i_reset_l) begin
    if (!i_reset_l)                             r_err <= 1'b0;
    else if (r_state == ST_CHECK && w_mismatch) r_err <= 1'b1;
    else if (i_err_clr)                         r_err <= 1'b0;
  end

  a_rs_excl: assert property (@(posedge i_clk) disable iff (!i_reset_l) !(r_r && r_s));

  assign o_gnt  = r_gnt;
  assign o_r    = r_r;
  assign o_s    = r_s;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_dbg  = '{state: r_state, cnt: r_cnt, exp_bit: r_exp, last: r_last};

endmodule

// File: tb/tb_sr_ff_arbiter.sv
// Bench for sr_ff_arbiter: directed scenarios plus random traffic, checked
// each cycle against a transaction-age reference model and an op scoreboard.
`timescale 1ns/1ps
module tb_sr_ff_arbiter;
  import sr_ff_pkg::*;

  localparam int SETTLE  = 2;
  localparam int CHK_AGE = SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] op = 2'b00;
  logic       err_clr = 1'b0;
  logic       q_fb;
  logic [1:0] gnt;
  logic       r, s, done, err;
  sr_ff_dbg_t dbg;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  sr_ff_arbiter #(.SETTLE_CYC(SETTLE), .CHECK_EN(1'b1)) dut (
    .i_clk     (clk),
    .i_reset_l (rst_n),
    .i_req     (req),
    .i_op      (op),
    .i_err_clr (err_clr),
    .i_q_fb    (q_fb),
    .o_gnt     (gnt),
    .o_r       (r),
    .o_s       (s),
    .o_done    (done),
    .o_err     (err),
    .o_dbg     (dbg)
  );

  // ---------------- environment: the shared SR flip-flop ----------------
  logic q_ff = 1'b0;
  int   q_mode = 0;      // 0: follow flop, 1: stuck at 0, 2: random
  logic q_rand = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q_ff <= 1'b0;
    else if (s)  q_ff <= 1'b1;
    else if (r)  q_ff <= 1'b0;
  end
  assign q_fb = (q_mode == 0) ? q_ff : (q_mode == 1) ? 1'b0 : q_rand;

  // ---------------- reference model: one op in flight, tracked by age ----------------
  logic       m_busy = 1'b0;
  int         m_age  = 0;
  int         m_g    = 0;
  logic       m_exp  = 1'b0;
  int         m_last = 1;
  logic       m_err  = 1'b0;
  logic [1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_age = 0; m_g = 0; m_exp = 1'b0; m_last = 1; m_err = 1'b0;
      exp_q.delete();
    end else begin
      if (m_busy && m_age == CHK_AGE && q_fb != m_exp) m_err = 1'b1;
      else if (err_clr)                                m_err = 1'b0;
      if (m_busy) begin
        if (m_age == CHK_AGE) m_busy = 1'b0;
        else                  m_age++;
      end else if (req != 2'b00) begin
        if (req == 2'b11) m_g = 1 - m_last;
        else              m_g = req[1] ? 1 : 0;
        m_last = m_g;
        m_exp  = op[m_g];
        m_busy = 1'b1;
        m_age  = 0;
        exp_q.push_back({m_g[0], m_exp});
      end
    end
  end

  function automatic logic [5:0] model_outs();
    logic [1:0] g;
    logic       drv;
    g   = m_busy ? ((m_g == 1) ? 2'b10 : 2'b01) : 2'b00;
    drv = m_busy && (m_age == 0);
    return {g, drv && !m_exp, drv && m_exp, m_busy && (m_age == CHK_AGE), m_err};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- per-cycle checker and scoreboard ----------------
  logic       chk_on = 1'b0;
  logic [1:0] rec = 2'b00;
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("outs", 8'({gnt, r, s, done, err}), 8'(model_outs()));
      chk("rs_excl", 8'(r & s), 8'd0);
      if (r | s) rec = {gnt[1], s};
      if (done) begin
        chk("sb_pending", 8'(exp_q.size() != 0), 8'd1);
        if (exp_q.size() != 0) chk("sb_op", 8'({gnt[1], rec[0]}), 8'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    chk("done_seen", 8'(done), 8'd1);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", 8'({gnt, r, s, done, err}), 8'd0);
    chk("rst_last", 8'(dbg.last), 8'd1);
    chk("rst_state", 8'(dbg.state), 8'(ST_IDLE));
  endtask

  logic [1:0] want_g[3]  = '{2'b01, 2'b10, 2'b01};
  logic [1:0] want_rs[3] = '{2'b10, 2'b01, 2'b10};

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs0", 8'({gnt, r, s, done, err}), 8'd0);
    chk("rst_dbg0", 8'(dbg), 8'b0000_0001);

    // Single set request right out of reset, Q follows the flop.
    chk_on = 1'b1;
    rst_n = 1'b1; req = 2'b01; op = 2'b01;
    @(negedge clk);
    chk("drv_set", 8'({gnt, r, s}), 8'b0000_0101);
    wait_done(n);
    chk("latency", 8'(n + 1), 8'(SETTLE + 2));
    req = 2'b00;
    @(negedge clk);
    chk("err_ok", 8'(err), 8'd0);

    // Contention from reset: grants alternate, pulse type follows each OP bit.
    @(negedge clk);
    async_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 2'b11; op = 2'b10;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        chk("idle_gap", 8'(gnt), 8'd0);
      end
      @(negedge clk);
      chk($sformatf("alt_gnt%0d", k), 8'(gnt), 8'(want_g[k]));
      chk($sformatf("alt_rs%0d", k), 8'({r, s}), 8'(want_rs[k]));
      wait_done(n);
    end
    req = 2'b00;
    @(negedge clk);

    // Readback stuck low: ERR is sticky until ERR_CLR.
    q_mode = 1; req = 2'b01; op = 2'b01;
    wait_done(n);
    req = 2'b00;
    @(negedge clk);
    chk("err_set", 8'(err), 8'd1);
    q_mode = 0; req = 2'b01; op = 2'b00;
    wait_done(n);
    req = 2'b00;
    @(negedge clk);
    chk("err_sticky", 8'(err), 8'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 8'(err), 8'd0);

    // Mismatch coinciding with ERR_CLR: set wins, then clear takes effect.
    q_mode = 1; req = 2'b01; op = 2'b01; err_clr = 1'b1;
    wait_done(n);
    req = 2'b00;
    @(negedge clk);
    chk("err_beats_clr", 8'(err), 8'd1);
    @(negedge clk);
    chk("err_clr_after", 8'(err), 8'd0);
    err_clr = 1'b0; q_mode = 0;

    // Reset during SETTLE abandons the op; first contention then goes to requester 0.
    req = 2'b01; op = 2'b01;
    @(negedge clk);
    @(negedge clk);
    async_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 2'b11; op = 2'b00;
    @(negedge clk);
    chk("post_rst_gnt", 8'(gnt), 8'b01);
    wait_done(n);
    req = 2'b00;
    @(negedge clk);

    // REQ/OP churn after grant must not disturb the pulse or the DONE timing.
    req = 2'b10; op = 2'b10;
    @(negedge clk);
    chk("churn_drv", 8'({gnt, r, s}), 8'b0000_1001);
    req = 2'b00; op = 2'b01;
    @(negedge clk);
    req = 2'b01; op = 2'b11;
    wait_done(n);
    chk("churn_lat", 8'(n + 2), 8'(SETTLE + 2));
    chk("churn_gnt", 8'(gnt), 8'b10);
    req = 2'b00;
    @(negedge clk);

    // Random traffic with occasional bad readback, ERR_CLR and async resets.
    for (int i = 0; i < 600; i++) begin
      if (i == 200 || i == 410) begin
        async_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      op      = 2'($urandom_range(0, 3));
      err_clr = ($urandom_range(0, 7) == 0);
      q_mode  = ($urandom_range(0, 3) == 0) ? 2 : 0;
      q_rand  = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req = 2'b00; err_clr = 1'b0; q_mode = 0;
    repeat (SETTLE + 4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
